perceptron_node: RTL and testbench

//   Single perceptron compute node driven over a UART byte link from a host.

---
 rtl/perceptron_node.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_perceptron_node.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_node.sv
// -----------------------------------------------------------------------------
// perceptron_node
//   Single perceptron compute node reached over a UART byte link. The host
//   sends frames of ADDR, CMD and, for the load commands, a 32-bit
//   little-endian operand. The node holds two operands (A, B) and a 32-bit
//   result R. It computes R = A*B or R = R + A*B, and sends R back on uart_tx
//   when asked.
//
//   Link: 8N1, LSB first, CLKS_PER_BIT clocks per bit. Receive and transmit run
//   independently, so the host may keep sending while a reply is in flight.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit
//   NODE_ADDR     frame address this node answers to
//
// Ports
//   clk      system clock (only clock in the block)
//   nRst     asynchronous, active-low reset
//   host_tx  serial line from the host (idle high)
//   uart_tx  serial line to the host (idle high)
//
// Commands (acted on only when ADDR matched)
//   0 LOAD_A  1 LOAD_B  2 OUT  3 CLR  5 MUL  6 MULADD  others ignored
// -----------------------------------------------------------------------------
module perceptron_node #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  NODE_ADDR    = 8'd101
) (
  input  logic clk,
  input  logic nRst,
  input  logic host_tx,
  output logic uart_tx
);

  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] CMD_LOAD_A = 8'd0;
  localparam logic [7:0] CMD_LOAD_B = 8'd1;
  localparam logic [7:0] CMD_OUT    = 8'd2;
  localparam logic [7:0] CMD_CLR    = 8'd3;
  localparam logic [7:0] CMD_MUL    = 8'd5;
  localparam logic [7:0] CMD_MULADD = 8'd6;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    F_WAIT_ADDR,
    F_WAIT_CMD,
    F_DATA0,
    F_DATA1,
    F_DATA2,
    F_DATA3
  } frame_state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  // NOTE: the synchroniser resets to the idle-high line level. This stops reset
  // release from looking like a start-bit falling edge.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= host_tx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  rx_state_t      rx_state;
  logic [CW-1:0]  rx_cnt;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_shift;
  logic [7:0]     rx_byte;
  logic           rx_valid;

  // NOTE: all state registers use non-blocking assignments. Every flop then
  // samples pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          // A start bit is a falling edge, not just a low level. A line left
          // low after a bad stop bit therefore cannot retrigger reception.
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            // A framing error drops the byte silently.
            if (rx_sync) begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operands, product pipeline and frame FSM
  // ---------------------------------------------------------------------------
  frame_state_t  f_state;
  logic          addr_hit;
  logic          load_b;
  logic [23:0]   operand;
  logic [31:0]   a_q, b_q, r_q, prod_q;
  logic          tx_start;
  logic [31:0]   tx_data;
  logic          tx_busy;

  // A and B change only on the last operand byte. At least one more byte must
  // arrive before any arithmetic command, so a registered product is always
  // current when used. This keeps the 32x32 multiply off the R update path.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) prod_q <= '0;
    else       prod_q <= a_q * b_q;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      f_state  <= F_WAIT_ADDR;
      addr_hit <= 1'b0;
      load_b   <= 1'b0;
      operand  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      if (rx_valid) begin
        case (f_state)
          F_WAIT_ADDR: begin
            addr_hit <= (rx_byte == NODE_ADDR);
            f_state  <= F_WAIT_CMD;
          end
          F_WAIT_CMD: begin
            // Foreign frames still walk their operand bytes to stay in step.
            if (rx_byte == CMD_LOAD_A || rx_byte == CMD_LOAD_B) begin
              load_b  <= (rx_byte == CMD_LOAD_B);
              f_state <= F_DATA0;
            end else begin
              f_state <= F_WAIT_ADDR;
              if (addr_hit) begin
                case (rx_byte)
                  CMD_OUT: begin
                    // tx_start covers the one cycle before tx_busy rises.
                    if (!tx_busy && !tx_start) begin
                      tx_start <= 1'b1;
                      tx_data  <= r_q;
                    end
                  end
                  CMD_CLR:    r_q <= '0;
                  CMD_MUL:    r_q <= prod_q;
                  CMD_MULADD: r_q <= r_q + prod_q;
                  default:    ;
                endcase
              end
            end
          end
          F_DATA0: begin
            operand[7:0] <= rx_byte;
            f_state      <= F_DATA1;
          end
          F_DATA1: begin
            operand[15:8] <= rx_byte;
            f_state       <= F_DATA2;
          end
          F_DATA2: begin
            operand[23:16] <= rx_byte;
            f_state        <= F_DATA3;
          end
          F_DATA3: begin
            if (addr_hit) begin
              if (load_b) b_q <= {rx_byte, operand};
              else        a_q <= {rx_byte, operand};
            end
            f_state <= F_WAIT_ADDR;
          end
          default: f_state <= F_WAIT_ADDR;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // UART transmitter: four bytes of the captured R, back-to-back, LSB first
  // ---------------------------------------------------------------------------
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [1:0]    tx_byte;
  logic [9:0]    tx_frame;   // {stop, data[7:0], start}, shifted out LSB first
  logic [23:0]   tx_buf;     // bytes still to send after the current one

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      tx_frame <= '1;
      tx_buf   <= '0;
      uart_tx  <= 1'b1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      tx_frame <= {1'b1, tx_data[7:0], 1'b0};
      tx_buf   <= tx_data[31:8];
      uart_tx  <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          if (tx_byte == 2'd3) begin
            tx_busy <= 1'b0;
            uart_tx <= 1'b1;
          end else begin
            tx_byte  <= tx_byte + 1'b1;
            tx_bit   <= '0;
            tx_frame <= {1'b1, tx_buf[7:0], 1'b0};
            tx_buf   <= {8'h00, tx_buf[23:8]};
            uart_tx  <= 1'b0;
          end
        end else begin
          tx_bit   <= tx_bit + 1'b1;
          tx_frame <= {1'b1, tx_frame[9:1]};
          uart_tx  <= tx_frame[1];
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_perceptron_node.sv
// -----------------------------------------------------------------------------
// tb_perceptron_node
//   Drives host frames onto host_tx and keeps a small A/B/R model that pushes
//   the expected reply bytes when an OUT is sent. A monitor decodes uart_tx
//   into a received queue. Each test task compares the two queues.
//   CLKS_PER_BIT is shortened to keep run time small.
// -----------------------------------------------------------------------------
module tb_perceptron_node;

  localparam int         CPB  = 16;
  localparam logic [7:0] ADDR = 8'd101;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic host_tx = 1'b1;
  logic uart_tx;

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_q[$];   // {stop bit, data}
  logic [8:0]  got_q[$];
  logic [31:0] m_a = '0, m_b = '0, m_r = '0;

  always #5 clk = ~clk;

  perceptron_node #(.CLKS_PER_BIT(CPB), .NODE_ADDR(ADDR)) dut (
    .clk     (clk),
    .nRst    (nRst),
    .host_tx (host_tx),
    .uart_tx (uart_tx)
  );

  // Receive monitor: sample at bit centres, keep the stop bit for checking.
  initial begin : monitor
    logic [7:0] d;
    forever begin
      @(negedge uart_tx);
      repeat (CPB / 2) @(negedge clk);
      if (uart_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        got_q.push_back({uart_tx, d});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) host_tx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      host_tx = b[i];
      repeat (CPB) @(negedge clk);
    end
    host_tx = stop;
    repeat (CPB) @(negedge clk);
    host_tx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Non-OUT frame plus model update.
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] cmd,
                            input logic [31:0] op);
    send_byte(addr, 1'b1);
    send_byte(cmd, 1'b1);
    if (cmd <= 8'd1)
      for (int i = 0; i < 4; i++) send_byte(op[8*i +: 8], 1'b1);
    if (addr == ADDR) begin
      case (cmd)
        8'd0: m_a = op;
        8'd1: m_b = op;
        8'd3: m_r = '0;
        8'd5: m_r = m_a * m_b;
        8'd6: m_r = m_r + m_a * m_b;
        default: ;
      endcase
    end
  endtask

  // OUT frame; expected bytes are pushed unless the reply is meant to be dropped.
  task automatic send_out(input logic [7:0] addr, input bit expect_reply);
    if (addr == ADDR && expect_reply)
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, m_r[8*i +: 8]});
    send_byte(addr, 1'b1);
    send_byte(8'd2, 1'b1);
  endtask

  // Bounded wait for the monitor to collect as many bytes as are expected.
  task automatic wait_reply();
    for (int t = 0; t < 80 * CPB; t++) begin
      if (got_q.size() >= exp_q.size()) break;
      @(negedge clk);
    end
  endtask

  task automatic run_basic_sequence(input logic [7:0] addr, input bit expect_reply);
    send_frame(addr, 8'd0, 32'd1);
    send_frame(addr, 8'd1, 32'd1);
    send_frame(addr, 8'd5, 32'd0);
    send_frame(addr, 8'd6, 32'd0);
    send_out(addr, expect_reply);
  endtask

  task automatic test_reset();
    repeat (10) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_uart_tx_in_reset got %b expected 1", uart_tx);
    end
    nRst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_uart_tx_idle got %b expected 1", uart_tx);
    end
    send_out(ADDR, 1'b1);
    wait_reply();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_reply_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_reply got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_addr_mismatch();
    run_basic_sequence(8'd100, 1'b0);
    repeat (60 * CPB) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL mismatch_silent got %0d bytes expected 0", got_q.size());
    end
    got_q.delete();
    // MUL on our address exposes whether A/B were loaded by the foreign frame.
    send_frame(ADDR, 8'd5, 32'd0);
    send_out(ADDR, 1'b1);
    wait_reply();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mismatch_reply_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL mismatch_reply got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_basic();
    run_basic_sequence(ADDR, 1'b1);
    wait_reply();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_reply_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL basic_reply got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_repeat();
    // Leave the node mid-frame and mid-byte, then reset.
    send_byte(ADDR, 1'b1);
    send_byte(8'd0, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    @(negedge clk) host_tx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    nRst = 1'b0;
    host_tx = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_repeat_uart_tx got %b expected 1", uart_tx);
    end
    nRst = 1'b1;
    m_a = '0; m_b = '0; m_r = '0;
    repeat (10) @(negedge clk);
    run_basic_sequence(ADDR, 1'b1);
    wait_reply();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_repeat_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_repeat_reply got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_wrap();
    send_frame(ADDR, 8'd0, 32'hFFFF_FFFF);
    send_frame(ADDR, 8'd1, 32'd2);
    send_frame(ADDR, 8'd5, 32'd0);
    send_out(ADDR, 1'b1);                  // FE FF FF FF
    wait_reply();
    send_frame(ADDR, 8'd6, 32'd0);
    send_out(ADDR, 1'b1);                  // FC FF FF FF
    wait_reply();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_reply_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL wrap_reply got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_framing_error();
    send_byte(ADDR, 1'b1);
    send_byte(8'd0, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'hAA, 1'b0);                // bad stop bit: must be dropped
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    m_a = 32'h4433_2211;
    send_frame(ADDR, 8'd5, 32'd0);
    send_out(ADDR, 1'b1);
    wait_reply();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL framing_reply_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL framing_reply got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_bad_cmd();
    send_frame(ADDR, 8'd7, 32'd0);
    send_frame(ADDR, 8'd4, 32'd0);
    send_out(ADDR, 1'b1);
    wait_reply();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bad_cmd_reply_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL bad_cmd_reply got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    // Second OUT lands while the first reply is still going: ignored.
    send_out(ADDR, 1'b1);
    send_out(ADDR, 1'b0);
    wait_reply();
    repeat (60 * CPB) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL busy_out_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL busy_out_reply got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    // CLR during an in-flight reply must not change it; the next OUT sees 0.
    send_out(ADDR, 1'b1);
    send_frame(ADDR, 8'd3, 32'd0);
    wait_reply();
    send_out(ADDR, 1'b1);
    wait_reply();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL inflight_count got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL inflight_reply got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_addr_mismatch();
    test_basic();
    test_reset_repeat();
    test_wrap();
    test_framing_error();
    test_bad_cmd();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
